// File: rtl/lfsr_req_arbiter_if.sv
// Bundle of requester-side and generator-side signals around the shared LFSR arbiter.
// The slave modport is the arbiter's view; master is the surrounding logic's view.
interface lfsr_req_arbiter_if #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned DWIDTH = 8
);
    logic [NREQ-1:0]        req;
    logic [NREQ*DWIDTH-1:0] req_taps;
    logic [NREQ*DWIDTH-1:0] req_seq_num;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        rsp_valid;
    logic [DWIDTH-1:0]      rsp_data;
    logic                   rsp_err;
    logic                   gen_start;
    logic [DWIDTH-1:0]      gen_taps;
    logic [DWIDTH-1:0]      gen_seq_num;
    logic                   gen_busy;
    logic [DWIDTH-1:0]      gen_num;

    modport slave (
        input  req, req_taps, req_seq_num, gen_busy, gen_num,
        output gnt, rsp_valid, rsp_data, rsp_err, gen_start, gen_taps, gen_seq_num
    );

    modport master (
        output req, req_taps, req_seq_num, gen_busy, gen_num,
        input  gnt, rsp_valid, rsp_data, rsp_err, gen_start, gen_taps, gen_seq_num
    );
endinterface

// File: rtl/lfsr_req_arbiter.sv
// Round-robin arbiter sharing one LFSR generator between NREQ requesters:
// grant, launch, wait for the run, then return the result with a one-cycle pulse.
module lfsr_req_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned DWIDTH  = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input logic               wb_clk_i,
    input logic               wb_rst_i,
    lfsr_req_arbiter_if.slave bus
);
    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE,
        RESP
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, win_q, win_d;
    logic [TW-1:0]     timer_q;
    logic [NREQ-1:0]   gnt_q;
    logic [DWIDTH-1:0] taps_q, seq_q, data_q;
    logic              err_q;
    logic              found;
    logic              launch;
    logic              timeout_hit;
    int unsigned       idx;

    // Rotating priority scan starting at ptr_q
    always_comb begin
        win_d = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = (32'(ptr_q) + i) % NREQ;
            if (!found && bus.req[PW'(idx)]) begin
                found = 1'b1;
                win_d = PW'(idx);
            end
        end
    end

    assign launch = found && !bus.gen_busy;
    // Comparing against TIMEOUT-2 makes the pulse land TIMEOUT cycles after gen_start
    assign timeout_hit = (timer_q == TW'(TIMEOUT - 2));

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (launch) state_d = LAUNCH;
            LAUNCH:    state_d = WAIT_BUSY;
            WAIT_BUSY: begin
                if (bus.gen_busy) begin
                    state_d = WAIT_DONE;
                end else if (timeout_hit) begin
                    state_d = RESP;
                end
            end
            WAIT_DONE: if (!bus.gen_busy) state_d = RESP;
            RESP:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ptr_q   <= '0;
            win_q   <= '0;
            timer_q <= '0;
            gnt_q   <= '0;
            taps_q  <= '0;
            seq_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (launch) begin
                        win_q  <= win_d;
                        gnt_q  <= NREQ'(1) << win_d;
                        taps_q <= bus.req_taps[win_d*DWIDTH +: DWIDTH];
                        seq_q  <= bus.req_seq_num[win_d*DWIDTH +: DWIDTH];
                    end
                end
                LAUNCH: timer_q <= '0;
                WAIT_BUSY: begin
                    if (!bus.gen_busy) begin
                        timer_q <= timer_q + 1'b1;
                        if (timeout_hit) begin
                            data_q <= '0;
                            err_q  <= 1'b1;
                        end
                    end
                end
                WAIT_DONE: begin
                    if (!bus.gen_busy) begin
                        data_q <= bus.gen_num;
                        err_q  <= 1'b0;
                    end
                end
                RESP: begin
                    gnt_q <= '0;
                    ptr_q <= (win_q == PW'(NREQ - 1)) ? '0 : win_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.gnt         = gnt_q;
        bus.rsp_valid   = (state_q == RESP) ? gnt_q : '0;
        bus.rsp_data    = data_q;
        bus.rsp_err     = err_q;
        bus.gen_start   = (state_q == LAUNCH);
        bus.gen_taps    = taps_q;
        bus.gen_seq_num = seq_q;
    end
endmodule

// File: tb/tb_lfsr_req_arbiter.sv
// Directed bench for lfsr_req_arbiter: behavioural generator model plus a
// response scoreboard that expected results are pushed to as each request is driven.
module tb_lfsr_req_arbiter;
    localparam int unsigned NREQ = 4;
    localparam int unsigned DW   = 8;
    localparam int unsigned TMO  = 16;

    typedef struct packed {
        logic [NREQ-1:0] lane;
        logic [DW-1:0]   data;
        logic            err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;
    exp_t        sb[$];
    exp_t        mon_e;

    logic          m_busy = 1'b0;
    logic          f_busy = 1'b0;
    logic          m_en   = 1'b1;
    logic          m_xor  = 1'b0;
    int unsigned   m_hold = 6;
    int unsigned   m_cnt  = 0;
    logic [DW-1:0] m_num  = 8'h3C;
    logic [DW-1:0] g_num  = '0;
    logic [DW-1:0] tv [4] = '{8'h11, 8'h22, 8'h44, 8'h88};

    lfsr_req_arbiter_if #(.NREQ(NREQ), .DWIDTH(DW)) bus ();

    lfsr_req_arbiter #(.NREQ(NREQ), .DWIDTH(DW), .TIMEOUT(TMO)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign bus.gen_busy = m_busy | f_busy;
    assign bus.gen_num  = g_num;

    // Generator model: busy rises the cycle after gen_start and stays high m_hold cycles
    always @(posedge clk) begin
        if (m_busy) begin
            if (m_cnt <= 1) m_busy <= 1'b0;
            else            m_cnt  <= m_cnt - 1;
        end else if (m_en && bus.gen_start === 1'b1) begin
            m_busy <= 1'b1;
            m_cnt  <= m_hold;
            g_num  <= m_xor ? (bus.gen_taps ^ 8'h5A) : m_num;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_lane(input int unsigned k, input logic [DW-1:0] t, input logic [DW-1:0] s);
        bus.req_taps[k*DW +: DW]    = t;
        bus.req_seq_num[k*DW +: DW] = s;
    endtask

    task automatic push_exp(input logic [NREQ-1:0] lane, input logic [DW-1:0] data, input logic err);
        exp_t e;
        e.lane = lane;
        e.data = data;
        e.err  = err;
        sb.push_back(e);
    endtask

    task automatic wait_start(output int unsigned at);
        int unsigned n;
        n = 0;
        @(negedge clk);
        while (bus.gen_start !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("start_seen", 32'(bus.gen_start), 32'h1);
        at = cyc;
    endtask

    task automatic wait_rsp(output int unsigned at);
        int unsigned n;
        n = 0;
        @(negedge clk);
        while (bus.rsp_valid === '0 && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_seen", 32'(bus.rsp_valid !== '0), 32'h1);
        at = cyc;
    endtask

    always @(negedge clk) begin
        if (!rst && bus.rsp_valid !== '0) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 32'(bus.rsp_valid), 32'h0);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_lane", 32'(bus.rsp_valid), 32'(mon_e.lane));
                chk("rsp_data", 32'(bus.rsp_data), 32'(mon_e.data));
                chk("rsp_err", 32'(bus.rsp_err), 32'(mon_e.err));
            end
        end
    end

    initial begin
        int unsigned s, r, c0, b, ln, n;
        logic        bad;
        s = 0; r = 0; c0 = 0; b = 0; ln = 0; n = 0; bad = 1'b0;
        bus.req         = '0;
        bus.req_taps    = '0;
        bus.req_seq_num = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt",       32'(bus.gnt),         32'h0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid),   32'h0);
        chk("rst_rsp_data",  32'(bus.rsp_data),    32'h0);
        chk("rst_rsp_err",   32'(bus.rsp_err),     32'h0);
        chk("rst_gen_start", 32'(bus.gen_start),   32'h0);
        chk("rst_gen_taps",  32'(bus.gen_taps),    32'h0);
        chk("rst_gen_seq",   32'(bus.gen_seq_num), 32'h0);

        // Single transaction on lane 0
        @(posedge clk); #1;
        rst = 1'b0;
        set_lane(0, 8'hB8, 8'd5);
        bus.req = 4'b0001;
        c0 = cyc;
        push_exp(4'b0001, 8'h3C, 1'b0);
        wait_start(s);
        chk("t1_gnt_latency", s - c0, 32'h1);
        chk("t1_gnt",  32'(bus.gnt),         32'h1);
        chk("t1_taps", 32'(bus.gen_taps),    32'hB8);
        chk("t1_seq",  32'(bus.gen_seq_num), 32'h5);
        @(negedge clk);
        chk("t1_start_pulse", 32'(bus.gen_start), 32'h0);
        wait_rsp(r);
        bus.req = '0;
        chk("t1_rsp_latency", r - s, 32'h8);
        @(negedge clk);
        chk("t1_gnt_release", 32'(bus.gnt), 32'h0);

        // All four lanes held: round-robin order 0,1,2,3,0
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        m_xor  = 1'b1;
        m_hold = 2;
        for (int k = 0; k < 4; k++) set_lane(k, tv[k], 8'(k + 3));
        bus.req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            ln = t % 4;
            push_exp(4'(1 << ln), tv[ln] ^ 8'h5A, 1'b0);
        end
        for (int t = 0; t < 5; t++) begin
            ln = t % 4;
            wait_start(s);
            chk("t2_gnt",  32'(bus.gnt), 32'(1 << ln));
            chk("t2_taps", 32'(bus.gen_taps), 32'(tv[ln]));
            if (t > 0) chk("t2_idle_gap", s - r, 32'h2);
            wait_rsp(r);
            if (t == 4) bus.req = '0;
        end

        // Generator never answers: timeout response, then pointer advance
        @(negedge clk);
        m_en = 1'b0;
        set_lane(2, 8'h8E, 8'd7);
        bus.req = 4'b0100;
        push_exp(4'b0100, 8'h00, 1'b1);
        wait_start(s);
        wait_rsp(r);
        bus.req = '0;
        chk("t3_timeout_latency", r - s, 32'(TMO));
        @(negedge clk);
        m_en = 1'b1;
        set_lane(3, 8'h99, 8'd2);
        bus.req = 4'b1111;
        push_exp(4'b1000, 8'hC3, 1'b0);
        wait_start(s);
        chk("t3_ptr_advance", 32'(bus.gnt), 32'h8);
        wait_rsp(r);
        bus.req = '0;

        // Busy already high when reset releases
        @(negedge clk);
        f_busy = 1'b1;
        rst    = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_lane(1, 8'h2D, 8'd4);
        bus.req = 4'b0010;
        push_exp(4'b0010, 8'h77, 1'b0);
        repeat (5) begin
            @(negedge clk);
            chk("t4_hold_off", 32'(bus.gnt), 32'h0);
        end
        f_busy = 1'b0;
        c0 = cyc;
        wait_start(s);
        chk("t4_gnt_latency", s - c0, 32'h1);
        chk("t4_gnt", 32'(bus.gnt), 32'h2);
        wait_rsp(r);
        bus.req = '0;

        // Reset in WAIT_DONE, then the stale run is waited out
        @(negedge clk);
        m_hold = 20;
        set_lane(0, 8'h1F, 8'd20);
        bus.req = 4'b0001;
        wait_start(s);
        repeat (4) @(negedge clk);
        sb.delete();
        rst = 1'b1;
        @(negedge clk);
        chk("t5_gnt",       32'(bus.gnt),         32'h0);
        chk("t5_rsp_valid", 32'(bus.rsp_valid),   32'h0);
        chk("t5_rsp_data",  32'(bus.rsp_data),    32'h0);
        chk("t5_rsp_err",   32'(bus.rsp_err),     32'h0);
        chk("t5_gen_start", 32'(bus.gen_start),   32'h0);
        chk("t5_gen_taps",  32'(bus.gen_taps),    32'h0);
        chk("t5_gen_seq",   32'(bus.gen_seq_num), 32'h0);
        rst = 1'b0;
        m_hold = 3;
        push_exp(4'b0001, 8'h45, 1'b0);
        bad = 1'b0;
        n = 0;
        while (bus.gen_busy === 1'b1 && n < 64) begin
            if (bus.gnt !== '0 || bus.gen_start !== 1'b0) bad = 1'b1;
            @(negedge clk);
            n++;
        end
        chk("t5_stale_wait", 32'(bad), 32'h0);
        chk("t5_busy_fell", 32'(bus.gen_busy), 32'h0);
        b = cyc;
        wait_start(s);
        chk("t5_relaunch", s - b, 32'h1);
        wait_rsp(r);
        bus.req = '0;

        // Operand change and req drop after grant are ignored
        @(negedge clk);
        m_hold = 6;
        set_lane(2, 8'h8E, 8'd6);
        bus.req = 4'b0100;
        push_exp(4'b0100, 8'hD4, 1'b0);
        wait_start(s);
        chk("t6_gnt",  32'(bus.gnt), 32'h4);
        chk("t6_taps", 32'(bus.gen_taps), 32'h8E);
        repeat (3) @(negedge clk);
        set_lane(2, 8'hFF, 8'd6);
        bus.req = '0;
        @(negedge clk);
        chk("t6_taps_hold", 32'(bus.gen_taps), 32'h8E);
        wait_rsp(r);
        chk("t6_taps_resp", 32'(bus.gen_taps), 32'h8E);
        chk("t6_gnt_resp",  32'(bus.gnt), 32'h4);
        @(negedge clk);
        chk("t6_gnt_release", 32'(bus.gnt), 32'h0);

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lfsr_req_arbiter.md
Name: lfsr_req_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one LFSR pseudo-random generator between NREQ requesters.
- Each requester presents a tap mask and a sequence count. The arbiter grants one requester at a time and launches the generator with that requester's operands. It waits for the run to finish, then returns the generated value to the granted requester with a one-cycle response pulse.
- Sits between the user-area request logic and the generator's start/busy/num interface.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DWIDTH, 8, width of tap mask, sequence count and result.
- TIMEOUT, 16, maximum cycles to wait for gen_busy to rise after a launch.

Ports:
- wb_clk_i  input  1  clock.
- wb_rst_i  input  1  synchronous active-high reset.
- req  input  NREQ  per-requester request level.
- req_taps  input  NREQ*DWIDTH  tap masks; requester k occupies bits [k*DWIDTH +: DWIDTH].
- req_seq_num  input  NREQ*DWIDTH  sequence counts, same packing as req_taps.
- gnt  output  NREQ  one-hot grant, held for the whole transaction.
- rsp_valid  output  NREQ  one-hot, one-cycle response pulse.
- rsp_data  output  DWIDTH  result, shared by all requesters, valid with rsp_valid.
- rsp_err  output  1  launch timeout flag, valid with rsp_valid.
- gen_start  output  1  one-cycle launch pulse to the generator.
- gen_taps  output  DWIDTH  registered tap mask to the generator.
- gen_seq_num  output  DWIDTH  registered sequence count to the generator.
- gen_busy  input  1  generator running.
- gen_num  input  DWIDTH  generator result.

Behaviour:
- Reset (synchronous, wb_rst_i=1 at a clock edge) applies regardless of state:
  - state=IDLE, ptr=0, timer=0.
  - gnt=0, rsp_valid=0, rsp_data=0, rsp_err=0, gen_start=0, gen_taps=0, gen_seq_num=0.
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, RESP.
- IDLE:
  - Launch condition is |req and gen_busy=0.
  - Winner = first asserted req scanning ptr, ptr+1, …, wrapping mod NREQ.
  - On the launch condition, register gnt=onehot(winner), gen_taps=req_taps[winner], gen_seq_num=req_seq_num[winner], then go to LAUNCH.
  - If gen_busy=1 (for example, a run left over after a mid-operation reset), stay in IDLE.
- LAUNCH:
  - gen_start=1 for exactly this one cycle; timer cleared to 0; go to WAIT_BUSY.
- WAIT_BUSY:
  - gen_busy=1: go to WAIT_DONE.
  - Otherwise timer increments. When timer reaches TIMEOUT-1 with gen_busy still 0: rsp_data=0, rsp_err=1, go to RESP.
- WAIT_DONE:
  - On gen_busy=0: capture gen_num into rsp_data, rsp_err=0, go to RESP.
  - No timeout in this state; run length is bounded by gen_seq_num.
- RESP:
  - rsp_valid = gnt for this one cycle.
  - Then gnt=0, ptr=(winner+1) mod NREQ, back to IDLE.
  - rsp_data and rsp_err hold their values until the next RESP.
- gen_taps and gen_seq_num are stable from LAUNCH through RESP. Requester operand changes after the grant are ignored.
- Latency: request seen in IDLE at edge N → gen_start high in cycle N+1 → rsp_valid exactly one cycle after the cycle in which gen_busy is sampled low in WAIT_DONE.
- Minimum back-to-back spacing: one IDLE cycle between RESP and the next LAUNCH.
- A requester may drop req during its transaction. The transaction still completes and the response pulse is still issued.
- A requester holding req through its own RESP is re-arbitrated normally; round-robin still gives other active requesters priority first.
- Simultaneous requests: only the winner is granted; the losers wait with no state change.
- Out-of-range NREQ is not supported. gen_busy already high in LAUNCH is treated as a normal rise in WAIT_BUSY.

Test Plan:
- Reset, then req=4'b0001, taps=8'hB8, seq_num=8'd5; generator model raises busy one cycle after start, holds it 6 cycles, num=8'h3C → gnt=0001 one cycle after req; one gen_start pulse; rsp_valid=0001 with rsp_data=8'h3C, rsp_err=0; gnt returns to 0.
- req=4'b1111 held continuously → grant order 0,1,2,3,0; each gen_start preceded by exactly one IDLE cycle; gen_taps always matches the granted lane.
- Generator never raises busy, TIMEOUT=16 → rsp_valid pulse exactly 16 cycles after the gen_start cycle, with rsp_err=1 and rsp_data=0; ptr still advances.
- gen_busy held high at reset release, req=0010 asserted → no grant until busy falls; grant to lane 1 on the next cycle.
- Assert wb_rst_i during WAIT_DONE → next cycle: all outputs 0, state IDLE; the stale busy is waited out before a new launch.
- Lane 2 changes req_taps from 8'h8E to 8'hFF and drops req in mid-WAIT_DONE → gen_taps stays 8'h8E; rsp_valid=0100 still pulses.
